// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// Walks the buffer slots via muxd, decodes each returned byte and lights one anode at a time.
module display_scanner #(
   parameter int PRESCALE = 50000,
   parameter int CNT_W    = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [7:0]       salida,
   output logic [1:0]       muxd,
   output logic [3:0]       an,
   output logic [6:0]       seg,
   output logic             dp,
   output logic             frame_done
);

   typedef enum logic [1:0] {BLANK, WAIT, SHOW} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           state;
   logic [1:0]       digit;
   logic [CNT_W-1:0] cnt;
   logic             fd_q;

   // Hex nibble to active-high {g,f,e,d,c,b,a}; inverted at the register for the common-anode part.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= BLANK;
         digit <= 2'd0;
         cnt   <= '0;
         an    <= 4'hF;
         seg   <= 7'h7F;
         dp    <= 1'b1;
         fd_q  <= 1'b0;
      end else if (!en) begin
         state <= BLANK;
         cnt   <= '0;
         an    <= 4'hF;
         fd_q  <= 1'b0;
      end else begin
         case (state)
            BLANK: begin
               state <= WAIT;
               an    <= 4'hF;
               fd_q  <= 1'b0;
            end
            // salida now reflects muxd; capture it so the lit digit never glitches.
            WAIT: begin
               state <= SHOW;
               cnt   <= '0;
               seg   <= ~hex_to_seg(salida[3:0]);
               dp    <= ~salida[7];
               an    <= ~(4'b0001 << digit);
               fd_q  <= (digit == 2'd3) && (LAST == '0);
            end
            SHOW: begin
               if (cnt == LAST) begin
                  state <= BLANK;
                  cnt   <= '0;
                  digit <= digit + 2'd1;
                  an    <= 4'hF;
                  fd_q  <= 1'b0;
               end else begin
                  cnt   <= cnt + ONE;
                  fd_q  <= (digit == 2'd3) && ((cnt + ONE) == LAST);
               end
            end
            default: begin
               state <= BLANK;
               an    <= 4'hF;
               fd_q  <= 1'b0;
            end
         endcase
      end
   end

   assign muxd = digit;
   // Gated so an en drop or reset landing on the final SHOW cycle cannot leak a pulse.
   assign frame_done = fd_q & en & rst_n;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: expected lit phases are queued as stimulus is applied
// and compared against each blank/lit phase the scanner produces.
module tb_display_scanner;
   localparam int P = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] salida;
   logic [1:0] muxd;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_done;

   logic [7:0] slots [4];
   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic [7:0] blanks;
      logic [7:0] lit;
      logic [3:0] fds;
      logic [7:0] fd_at;
      logic       clean;
   } phase_t;

   phase_t expq[$];

   localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   display_scanner #(.PRESCALE(P), .CNT_W(20)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .salida(salida),
      .muxd(muxd), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Buffer read port: byte for muxd appears one clock later.
   always @(posedge clk) salida <= slots[muxd];

   function automatic phase_t exp_phase(input int d, input logic [7:0] b);
      phase_t p;
      p.an     = ~(4'b0001 << d);
      p.seg    = ~SEG_TAB[b[3:0]];
      p.dp     = ~b[7];
      p.blanks = 8'd2;
      p.lit    = 8'(P);
      p.fds    = (d == 3) ? 4'd1 : 4'd0;
      p.fd_at  = (d == 3) ? 8'(P - 1) : 8'd0;
      p.clean  = 1'b1;
      return p;
   endfunction

   // Records one blank run followed by one lit run; optional action after the hook_at-th lit cycle.
   task automatic measure(input int hook_at, input int hook, output phase_t p);
      int n;
      logic [7:0] t [4];
      p = '0;
      p.clean = 1'b1;
      n = 0;
      while (an === 4'hF && n < 100) begin
         if (frame_done) p.fds = p.fds + 4'd1;
         n++;
         @(negedge clk);
      end
      p.blanks = 8'(n);
      p.an = an;
      p.seg = seg;
      p.dp = dp;
      n = 0;
      while (an === p.an && an !== 4'hF && n < 100) begin
         if (seg !== p.seg || dp !== p.dp || $countones(~an) != 1) p.clean = 1'b0;
         if (frame_done) begin
            p.fds = p.fds + 4'd1;
            p.fd_at = 8'(n);
         end
         n++;
         if (n == hook_at) begin
            case (hook)
               1: begin
                  t = slots;
                  slots[0] = 8'h07;
                  slots[1] = t[0];
                  slots[2] = t[1];
                  slots[3] = t[2];
               end
               2: en = 1'b0;
               3: rst_n = 1'b0;
               default: ;
            endcase
         end
         @(negedge clk);
      end
      p.lit = 8'(n);
   endtask

   task automatic test_reset();
      phase_t p, e;
      rst_n = 1'b0;
      en = 1'b1;
      slots[0] = 8'h04; slots[1] = 8'h03; slots[2] = 8'h02; slots[3] = 8'h01;
      repeat (3) @(negedge clk);
      checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
      checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg); end
      checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp); end
      checks++; if (muxd !== 2'd0) begin failures++; $display("FAIL reset_muxd got=%0d exp=0", muxd); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
      rst_n = 1'b1;
      expq.push_back(exp_phase(0, slots[0]));
      measure(0, 0, p);
      e = expq.pop_front();
      checks++; if (p !== e) begin failures++; $display("FAIL first_digit got=%h exp=%h", p, e); end
   endtask

   task automatic test_full_frame();
      phase_t p, e;
      for (int d = 1; d < 4; d++) expq.push_back(exp_phase(d, slots[d]));
      for (int d = 0; d < 4; d++) expq.push_back(exp_phase(d, slots[d]));
      for (int i = 0; i < 7; i++) begin
         measure(0, 0, p);
         e = expq.pop_front();
         checks++; if (p !== e) begin failures++; $display("FAIL full_frame[%0d] got=%h exp=%h", i, p, e); end
      end
   endtask

   task automatic test_buffer_shift();
      phase_t p, e;
      logic [7:0] nb [4];
      nb[0] = 8'h07; nb[1] = slots[0]; nb[2] = slots[1]; nb[3] = slots[2];
      expq.push_back(exp_phase(0, slots[0]));
      expq.push_back(exp_phase(1, slots[1]));
      expq.push_back(exp_phase(2, nb[2]));
      expq.push_back(exp_phase(3, nb[3]));
      for (int d = 0; d < 4; d++) expq.push_back(exp_phase(d, nb[d]));
      for (int i = 0; i < 8; i++) begin
         if (i == 1) measure(2, 1, p);
         else measure(0, 0, p);
         e = expq.pop_front();
         checks++; if (p !== e) begin failures++; $display("FAIL buffer_shift[%0d] got=%h exp=%h", i, p, e); end
      end
   endtask

   task automatic test_decimal_point();
      phase_t p, e;
      slots[0] = 8'h85;
      slots[1] = 8'h70;
      for (int d = 0; d < 4; d++) expq.push_back(exp_phase(d, slots[d]));
      for (int i = 0; i < 4; i++) begin
         measure(0, 0, p);
         e = expq.pop_front();
         checks++; if (p !== e) begin failures++; $display("FAIL decimal_point[%0d] got=%h exp=%h", i, p, e); end
      end
   endtask

   task automatic test_en_toggle();
      phase_t p, e;
      slots[0] = 8'h04; slots[1] = 8'h03; slots[2] = 8'h02; slots[3] = 8'h01;
      expq.push_back(exp_phase(0, slots[0]));
      expq.push_back(exp_phase(1, slots[1]));
      e = exp_phase(2, slots[2]);
      e.lit = 8'd2; e.fds = 4'd0; e.fd_at = 8'd0;
      expq.push_back(e);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) measure(2, 2, p);
         else measure(0, 0, p);
         e = expq.pop_front();
         checks++; if (p !== e) begin failures++; $display("FAIL en_drop[%0d] got=%h exp=%h", i, p, e); end
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({an, muxd, frame_done} !== {4'hF, 2'd2, 1'b0}) begin
            failures++;
            $display("FAIL en_low[%0d] got an=%b muxd=%0d fd=%b exp an=1111 muxd=2 fd=0", i, an, muxd, frame_done);
         end
         @(negedge clk);
      end
      en = 1'b1;
      expq.push_back(exp_phase(2, slots[2]));
      expq.push_back(exp_phase(3, slots[3]));
      for (int i = 0; i < 2; i++) begin
         measure(0, 0, p);
         e = expq.pop_front();
         checks++; if (p !== e) begin failures++; $display("FAIL en_resume[%0d] got=%h exp=%h", i, p, e); end
      end
   endtask

   task automatic test_reset_mid_scan();
      phase_t p, e;
      for (int d = 0; d < 3; d++) expq.push_back(exp_phase(d, slots[d]));
      e = exp_phase(3, slots[3]);
      e.lit = 8'd2; e.fds = 4'd0; e.fd_at = 8'd0;
      expq.push_back(e);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) measure(2, 3, p);
         else measure(0, 0, p);
         e = expq.pop_front();
         checks++; if (p !== e) begin failures++; $display("FAIL mid_reset_scan[%0d] got=%h exp=%h", i, p, e); end
      end
      checks++;
      if ({an, seg, dp, muxd, frame_done} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
         failures++;
         $display("FAIL mid_reset_outputs got an=%b seg=%h dp=%b muxd=%0d fd=%b exp an=1111 seg=7f dp=1 muxd=0 fd=0",
                  an, seg, dp, muxd, frame_done);
      end
      rst_n = 1'b1;
      expq.push_back(exp_phase(0, slots[0]));
      expq.push_back(exp_phase(1, slots[1]));
      for (int i = 0; i < 2; i++) begin
         measure(0, 0, p);
         e = expq.pop_front();
         checks++; if (p !== e) begin failures++; $display("FAIL mid_reset_restart[%0d] got=%h exp=%h", i, p, e); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_full_frame();
      test_buffer_shift();
      test_decimal_point();
      test_en_toggle();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
